branch_resolve_unit: RTL and testbench
======================================

Name: branch_resolve_unit

Overview:
- Parametrised successor to the jump-enable selector.
- Evaluates the branch condition in EX from a full-width operand (zero/sign tests) instead of a precomputed zero flag.
- Holds a per-PC 2-bit saturating-counter predictor read by IF.
- Registers the resolved jump decision and a mispredict flag, then holds a flush window for a fixed number of cycles before accepting new branches.

Parameters:
- DATA_W, 16: width of the condition operand.
- PC_W, 16: width of the PC.
- BHT_IDX_W, 4: log2 of predictor depth; index = pc[BHT_IDX_W-1:0]; 16 entries at default.
- FLUSH_CYCLES, 2: cycles flush stays high after a mispredict; legal range 1..15.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous reset, active-high
- pred_pc  in  PC_W  IF-stage PC for lookup
- pred_taken  out  1  combinational: MSB of the counter at pred_pc index
- res_valid  in  1  EX presents a branch this cycle
- res_pc  in  PC_W  PC of the resolving branch
- res_op  in  3  condition: 0 NOP, 1 EN (always), 2 ZEROJ (operand==0), 3 NZEROJ (operand!=0), 4 LTZJ (operand MSB=1), 5 GEZJ (operand MSB=0), 6..7 treated as NOP
- res_operand  in  DATA_W  condition operand (alu_A)
- res_pred  in  1  prediction originally used for this branch
- jump_en  out  1  registered resolved decision
- mispredict  out  1  registered; decision != res_pred
- flush  out  1  high during flush window
- busy  out  1  high in FLUSH; res_valid ignored

Behaviour:
- Reset (rst=1 at clk edge):
  - jump_en=0, mispredict=0, flush=0, busy=0.
  - State=IDLE, flush counter=0.
  - All predictor counters=2'b01 (weakly not-taken).
- Condition evaluation (combinational, internal): cond = f(res_op, res_operand); NOP and codes 6..7 yield 0.
- Accept: res_valid=1 and state=IDLE.
- On accept, at next edge:
  - jump_en <= cond.
  - mispredict <= (cond != res_pred).
  - Counter at res_pc index updates: +1 saturating at 3 if cond=1, -1 saturating at 0 if cond=0.
  - NOP/invalid ops still update the counter toward not-taken.
- Not accepted cycles: jump_en <= 0, mispredict <= 0 (both are single-cycle pulses).
- FSM:
  - IDLE -> FLUSH when an accepted branch mispredicts.
    - Same edge: flush <= 1, busy <= 1, counter <= FLUSH_CYCLES-1.
  - FLUSH:
    - counter != 0: decrement each cycle.
    - counter == 0: next edge -> IDLE, flush <= 0, busy <= 0.
  - flush is high for exactly FLUSH_CYCLES cycles, starting the cycle mispredict is high.
  - res_valid in FLUSH: no counter update, no outputs.
- pred_taken: asynchronous read of the table.
  - Same-cycle read/write to the same index returns the old value; no bypass.
- Index aliasing: PCs sharing low BHT_IDX_W bits share a counter; this is intended.
- Reset mid-flush: synchronous reset wins; return to IDLE; table reinitialised.
- Latency: resolve to jump_en/mispredict = 1 cycle; resolve to predictor visible on pred_taken = 1 cycle.

Optional Feature:
- Macro: BRU_STATS_EN
- Defined: adds output ports stat_branches [31:0] and stat_mispredicts [31:0].
  - stat_branches increments on every accepted res_valid with a non-NOP op.
  - stat_mispredicts increments when mispredict is set.
  - Both wrap from 0xFFFFFFFF to 0; both cleared by rst.
- Undefined: ports and counters absent; all other behaviour identical.

Test Plan:
- Reset check: after rst, pred_pc=any -> pred_taken=0; jump_en=0, mispredict=0, flush=0.
- Conditions:
  - res_op=ZEROJ, operand=0, res_pred=0 -> next cycle jump_en=1, mispredict=1, flush high 2 cycles, busy high 2 cycles.
  - Then LTZJ, operand=0x8000, res_pred=1 -> jump_en=1, mispredict=0.
- Saturation: four taken EN branches at pc=0x0013 (no mispredict after the 2nd) -> counter 3, pred_taken=1 at pc=0x0003. Five not-taken (NZEROJ, operand=0) -> counter 0, pred_taken=0.
- Flush gating: mispredict followed by res_valid on each of the next 2 cycles -> those branches ignored (no jump_en, no table change); branch in the 3rd cycle accepted.
- Reset mid-flush: rst asserted in the 1st flush cycle -> next cycle flush=0, busy=0; table back to 01.
- BRU_STATS_EN build: 10 non-NOP branches, 3 mispredicting, plus 2 NOPs -> stat_branches=10, stat_mispredicts=3.

Source files
------------

// File: rtl/branch_resolve_if.sv
// Branch resolve bus: IF-side predictor lookup plus EX-side resolution and the
// registered decision/flush results handed back to the pipeline.
interface branch_resolve_if #(
  parameter int DATA_W = 16,
  parameter int PC_W   = 16
);
  logic [PC_W-1:0]   pred_pc;
  logic              pred_taken;
  logic              res_valid;
  logic [PC_W-1:0]   res_pc;
  logic [2:0]        res_op;
  logic [DATA_W-1:0] res_operand;
  logic              res_pred;
  logic              jump_en;
  logic              mispredict;
  logic              flush;
  logic              busy;

  modport master (
    output pred_pc, res_valid, res_pc, res_op, res_operand, res_pred,
    input  pred_taken, jump_en, mispredict, flush, busy
  );

  modport slave (
    input  pred_pc, res_valid, res_pc, res_op, res_operand, res_pred,
    output pred_taken, jump_en, mispredict, flush, busy
  );
endinterface

// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: EX-stage condition evaluation, 2-bit saturating BHT and
// mispredict flush window. Define BRU_STATS_EN to add branch/mispredict counters.
module branch_resolve_unit #(
  parameter int DATA_W       = 16,
  parameter int PC_W         = 16,
  parameter int BHT_IDX_W    = 4,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  branch_resolve_if.slave bif
`ifdef BRU_STATS_EN
  ,
  output logic [31:0] stat_branches,
  output logic [31:0] stat_mispredicts
`endif
);
  localparam int DEPTH = 1 << BHT_IDX_W;

  typedef enum logic [2:0] {
    OP_NOP = 3'd0, OP_EN = 3'd1, OP_ZEROJ = 3'd2, OP_NZEROJ = 3'd3,
    OP_LTZJ = 3'd4, OP_GEZJ = 3'd5
  } op_e;

  typedef enum logic {IDLE = 1'b0, FLUSH = 1'b1} state_e;

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       flush_q, flush_d;
  logic       busy_q, busy_d;
  logic       jump_en_q, jump_en_d;
  logic       misp_q, misp_d;
  logic [1:0] bht_q [DEPTH];
  logic [1:0] bht_d [DEPTH];

  logic                 cond;
  logic                 accept;
  logic                 non_nop;
  logic [BHT_IDX_W-1:0] res_idx;
  logic [BHT_IDX_W-1:0] pred_idx;

  assign res_idx  = bif.res_pc[BHT_IDX_W-1:0];
  assign pred_idx = bif.pred_pc[BHT_IDX_W-1:0];
  assign accept   = bif.res_valid && (state_q == IDLE);

  // Table read is the registered state only, so a same-cycle update is not seen.
  assign bif.pred_taken = bht_q[pred_idx][1];
  assign bif.jump_en    = jump_en_q;
  assign bif.mispredict = misp_q;
  assign bif.flush      = flush_q;
  assign bif.busy       = busy_q;

  always_comb begin
    cond    = 1'b0;
    non_nop = 1'b1;
    case (bif.res_op)
      OP_EN:     cond = 1'b1;
      OP_ZEROJ:  cond = (bif.res_operand == '0);
      OP_NZEROJ: cond = (bif.res_operand != '0);
      OP_LTZJ:   cond = bif.res_operand[DATA_W-1];
      OP_GEZJ:   cond = ~bif.res_operand[DATA_W-1];
      default:   non_nop = 1'b0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    flush_d   = flush_q;
    busy_d    = busy_q;
    jump_en_d = 1'b0;
    misp_d    = 1'b0;
    bht_d     = bht_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          jump_en_d = cond;
          misp_d    = (cond != bif.res_pred);
          if (cond && bht_q[res_idx] != 2'b11)
            bht_d[res_idx] = bht_q[res_idx] + 2'b01;
          else if (!cond && bht_q[res_idx] != 2'b00)
            bht_d[res_idx] = bht_q[res_idx] - 2'b01;
          if (misp_d) begin
            state_d = FLUSH;
            flush_d = 1'b1;
            busy_d  = 1'b1;
            cnt_d   = 4'(FLUSH_CYCLES - 1);
          end
        end
      end
      FLUSH: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = IDLE;
          flush_d = 1'b0;
          busy_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      flush_q   <= 1'b0;
      busy_q    <= 1'b0;
      jump_en_q <= 1'b0;
      misp_q    <= 1'b0;
      for (int i = 0; i < DEPTH; i++) bht_q[i] <= 2'b01;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      flush_q   <= flush_d;
      busy_q    <= busy_d;
      jump_en_q <= jump_en_d;
      misp_q    <= misp_d;
      for (int i = 0; i < DEPTH; i++) bht_q[i] <= bht_d[i];
    end
  end

`ifdef BRU_STATS_EN
  logic [31:0] stat_br_q, stat_br_d;
  logic [31:0] stat_mp_q, stat_mp_d;

  always_comb begin
    stat_br_d = stat_br_q;
    stat_mp_d = stat_mp_q;
    if (accept && non_nop) stat_br_d = stat_br_q + 32'd1;
    if (misp_d)            stat_mp_d = stat_mp_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_br_q <= '0;
      stat_mp_q <= '0;
    end else begin
      stat_br_q <= stat_br_d;
      stat_mp_q <= stat_mp_d;
    end
  end

  assign stat_branches    = stat_br_q;
  assign stat_mispredicts = stat_mp_q;
`else
  // Op classification only feeds the stats counters.
  logic unused_non_nop;
  assign unused_non_nop = non_nop;
`endif
endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit: conditions, BHT saturation, flush
// gating and reset during flush; counter checks when BRU_STATS_EN is defined.
module tb_branch_resolve_unit;
  logic clk;
  logic rst;
  int   checks;
  int   failures;

  branch_resolve_if #(.DATA_W(16), .PC_W(16)) bif ();

`ifdef BRU_STATS_EN
  logic [31:0] stat_branches;
  logic [31:0] stat_mispredicts;
`endif

  branch_resolve_unit #(
    .DATA_W(16), .PC_W(16), .BHT_IDX_W(4), .FLUSH_CYCLES(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bif(bif)
`ifdef BRU_STATS_EN
    ,
    .stat_branches(stat_branches),
    .stat_mispredicts(stat_mispredicts)
`endif
  );

  always #5 clk = ~clk;

  // Present one branch for a single edge; outputs are sampled 1ns after it.
  task automatic drive(input logic [15:0] pc, input logic [2:0] op,
                       input logic [15:0] opnd, input logic pr);
    bif.res_valid   = 1'b1;
    bif.res_pc      = pc;
    bif.res_op      = op;
    bif.res_operand = opnd;
    bif.res_pred    = pr;
    @(posedge clk); #1;
    bif.res_valid   = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle(2);
    for (int p = 0; p < 16; p += 5) begin
      bif.pred_pc = 16'(p); #1;
      checks++;
      if (bif.pred_taken !== 1'b0) begin
        failures++;
        $display("FAIL reset_pred_taken pc=%0d got=%b exp=0", p, bif.pred_taken);
      end
    end
    checks++;
    if ({bif.jump_en, bif.mispredict, bif.flush, bif.busy} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_outputs got je/mp/fl/bz=%b exp=0000",
               {bif.jump_en, bif.mispredict, bif.flush, bif.busy});
    end
    rst = 1'b0;
  endtask

  task automatic test_conditions();
    logic [2:0]  ops   [10] = '{3'd1, 3'd2, 3'd2, 3'd3, 3'd3, 3'd4, 3'd5, 3'd5, 3'd0, 3'd7};
    logic [15:0] opnds [10] = '{16'h1234, 16'h0000, 16'h0001, 16'h0005, 16'h0000,
                                16'hFFFF, 16'h8000, 16'h7FFF, 16'h0000, 16'h0000};
    logic        exps  [10] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    // ZEROJ taken with a not-taken prediction: mispredict and a 2-cycle flush.
    bif.pred_pc = 16'h0010;
    drive(16'h0010, 3'd2, 16'h0000, 1'b0);
    checks++;
    if ({bif.jump_en, bif.mispredict, bif.flush, bif.busy} !== 4'b1111) begin
      failures++;
      $display("FAIL zeroj_mispredict got je/mp/fl/bz=%b exp=1111",
               {bif.jump_en, bif.mispredict, bif.flush, bif.busy});
    end
    checks++;
    if (bif.pred_taken !== 1'b1) begin
      failures++;
      $display("FAIL zeroj_bht_update got=%b exp=1", bif.pred_taken);
    end
    idle(1);
    checks++;
    if ({bif.jump_en, bif.mispredict, bif.flush, bif.busy} !== 4'b0011) begin
      failures++;
      $display("FAIL flush_cycle2 got je/mp/fl/bz=%b exp=0011",
               {bif.jump_en, bif.mispredict, bif.flush, bif.busy});
    end
    idle(1);
    checks++;
    if ({bif.flush, bif.busy} !== 2'b00) begin
      failures++;
      $display("FAIL flush_end got fl/bz=%b exp=00", {bif.flush, bif.busy});
    end
    drive(16'h0020, 3'd4, 16'h8000, 1'b1);
    checks++;
    if ({bif.jump_en, bif.mispredict, bif.flush} !== 3'b100) begin
      failures++;
      $display("FAIL ltzj_predicted got je/mp/fl=%b exp=100",
               {bif.jump_en, bif.mispredict, bif.flush});
    end
    for (int i = 0; i < 10; i++) begin
      drive(16'h001F, ops[i], opnds[i], exps[i]);
      checks++;
      if ({bif.jump_en, bif.mispredict} !== {exps[i], 1'b0}) begin
        failures++;
        $display("FAIL cond_op%0d operand=%h got je/mp=%b%b exp=%b0",
                 ops[i], opnds[i], bif.jump_en, bif.mispredict, exps[i]);
      end
    end
    idle(1);
    checks++;
    if (bif.jump_en !== 1'b0) begin
      failures++;
      $display("FAIL jump_en_pulse got=%b exp=0", bif.jump_en);
    end
  endtask

  task automatic test_saturation();
    logic exp_msb [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    bif.pred_pc = 16'h0003;
    // Write and read the same index in one cycle: the old value must show.
    bif.res_valid = 1'b1; bif.res_pc = 16'h0013; bif.res_op = 3'd1; bif.res_pred = 1'b0;
    #1;
    checks++;
    if (bif.pred_taken !== 1'b0) begin
      failures++;
      $display("FAIL no_bypass got=%b exp=0", bif.pred_taken);
    end
    drive(16'h0013, 3'd1, 16'h0000, 1'b0);
    idle(2);
    for (int i = 0; i < 3; i++) begin
      drive(16'h0013, 3'd1, 16'h0000, 1'b1);
      checks++;
      if (bif.mispredict !== 1'b0) begin
        failures++;
        $display("FAIL sat_up_mp%0d got=%b exp=0", i, bif.mispredict);
      end
    end
    checks++;
    if (bif.pred_taken !== 1'b1) begin
      failures++;
      $display("FAIL sat_high got=%b exp=1", bif.pred_taken);
    end
    for (int i = 0; i < 5; i++) begin
      drive(16'h0013, 3'd3, 16'h0000, 1'b0);
      checks++;
      if (bif.pred_taken !== exp_msb[i] || bif.mispredict !== 1'b0) begin
        failures++;
        $display("FAIL sat_down%0d got pt/mp=%b%b exp=%b0",
                 i, bif.pred_taken, bif.mispredict, exp_msb[i]);
      end
    end
    // Counter at 00: one taken step must land on 01 (still not-taken).
    drive(16'h0013, 3'd1, 16'h0000, 1'b0);
    checks++;
    if (bif.pred_taken !== 1'b0) begin
      failures++;
      $display("FAIL sat_low_floor got=%b exp=0", bif.pred_taken);
    end
    idle(2);
  endtask

  task automatic test_flush_gating();
    do_reset();
    bif.pred_pc = 16'h0006;
    drive(16'h0005, 3'd1, 16'h0000, 1'b0);
    for (int i = 0; i < 2; i++) begin
      drive(16'h0006, 3'd1, 16'h0000, 1'b0);
      checks++;
      if ({bif.jump_en, bif.mispredict} !== 2'b00) begin
        failures++;
        $display("FAIL gated%0d got je/mp=%b%b exp=00", i, bif.jump_en, bif.mispredict);
      end
    end
    checks++;
    if ({bif.flush, bif.pred_taken} !== 2'b00) begin
      failures++;
      $display("FAIL gated_table got fl/pt=%b%b exp=00", bif.flush, bif.pred_taken);
    end
    drive(16'h0006, 3'd1, 16'h0000, 1'b1);
    checks++;
    if ({bif.jump_en, bif.mispredict, bif.pred_taken} !== 3'b101) begin
      failures++;
      $display("FAIL after_flush got je/mp/pt=%b exp=101",
               {bif.jump_en, bif.mispredict, bif.pred_taken});
    end
  endtask

  task automatic test_reset_mid_flush();
    bif.pred_pc = 16'h0007;
    drive(16'h0007, 3'd1, 16'h0000, 1'b0);
    checks++;
    if ({bif.flush, bif.pred_taken} !== 2'b11) begin
      failures++;
      $display("FAIL midflush_setup got fl/pt=%b%b exp=11", bif.flush, bif.pred_taken);
    end
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    checks++;
    if ({bif.flush, bif.busy, bif.pred_taken} !== 3'b000) begin
      failures++;
      $display("FAIL midflush_reset got fl/bz/pt=%b exp=000",
               {bif.flush, bif.busy, bif.pred_taken});
    end
    bif.pred_pc = 16'h0006; #1;
    checks++;
    if (bif.pred_taken !== 1'b0) begin
      failures++;
      $display("FAIL midflush_table got=%b exp=0", bif.pred_taken);
    end
    drive(16'h0008, 3'd1, 16'h0000, 1'b1);
    checks++;
    if ({bif.jump_en, bif.mispredict, bif.busy} !== 3'b100) begin
      failures++;
      $display("FAIL midflush_accept got je/mp/bz=%b exp=100",
               {bif.jump_en, bif.mispredict, bif.busy});
    end
  endtask

`ifdef BRU_STATS_EN
  task automatic test_stats();
    do_reset();
    checks++;
    if (stat_branches !== 32'd0 || stat_mispredicts !== 32'd0) begin
      failures++;
      $display("FAIL stats_reset got br=%0d mp=%0d exp=0/0", stat_branches, stat_mispredicts);
    end
    for (int i = 0; i < 7; i++) drive(16'h0009, 3'd1, 16'h0000, 1'b1);
    for (int i = 0; i < 3; i++) begin
      drive(16'h000A, 3'd1, 16'h0000, 1'b0);
      idle(2);
    end
    drive(16'h000B, 3'd0, 16'h0000, 1'b0);
    drive(16'h000B, 3'd6, 16'h0000, 1'b0);
    idle(1);
    checks++;
    if (stat_branches !== 32'd10 || stat_mispredicts !== 32'd3) begin
      failures++;
      $display("FAIL stats_count got br=%0d mp=%0d exp=10/3", stat_branches, stat_mispredicts);
    end
  endtask
`endif

  initial begin
    clk = 1'b0;
    rst = 1'b1;
    checks = 0;
    failures = 0;
    bif.pred_pc = '0;
    bif.res_valid = 1'b0;
    bif.res_pc = '0;
    bif.res_op = '0;
    bif.res_operand = '0;
    bif.res_pred = 1'b0;
    test_reset();
    test_conditions();
    test_saturation();
    test_flush_gating();
    test_reset_mid_flush();
`ifdef BRU_STATS_EN
    test_stats();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
